// File: rtl/fib_codec_pkg.sv
// fib_codec_pkg: shared state type, Fibonacci weight helpers and the seed pair
// for the default 24-digit configuration.
package fib_codec_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int unsigned fib_weight(input int k);
    int unsigned a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  function automatic int wgt_bits(input int fib_w);
    return $clog2(fib_weight(fib_w + 1) + 1);
  endfunction
  localparam int DEF_FIB_W = 24;
  localparam int WGT_W = wgt_bits(DEF_FIB_W);
  localparam logic [WGT_W-1:0] TOP_HI = WGT_W'(fib_weight(DEF_FIB_W + 1));
  localparam logic [WGT_W-1:0] TOP_LO = WGT_W'(fib_weight(DEF_FIB_W));
endpackage

// File: rtl/fib_weight_gen.sv
// fib_weight_gen: descending Fibonacci weight walker, (hi, lo) -> (lo, hi-lo).
module fib_weight_gen #(
  parameter int WGT_W = 17,
  parameter logic [WGT_W-1:0] SEED_HI = '0,
  parameter logic [WGT_W-1:0] SEED_LO = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  output logic [WGT_W-1:0] wgt_o
);
  logic [WGT_W-1:0] hi_q, hi_d, lo_q, lo_d;
  always_comb begin
    hi_d = load_i ? SEED_HI : step_i ? lo_q : hi_q;
    lo_d = load_i ? SEED_LO : step_i ? hi_q - lo_q : lo_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign wgt_o = hi_q;
endmodule

// File: rtl/fib_codec.sv
// fib_codec: serial binary <-> Zeckendorf (Fibonacci) converter, one digit per
// cycle from the most significant digit down.
module fib_codec
  import fib_codec_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int FIB_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] bin_in,
  input  logic [FIB_W-1:0] fib_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FIB_W-1:0] fib_out,
  output logic [BIN_W-1:0] bin_out,
  output logic             err,
  output logic             busy
);
  localparam int WW = wgt_bits(FIB_W);
  localparam int ACC_W = WW + 1;
  localparam int CW = $clog2(FIB_W + 1);
  localparam logic [WW-1:0] SEED_HI = WW'(fib_weight(FIB_W + 1));
  localparam logic [WW-1:0] SEED_LO = WW'(fib_weight(FIB_W));
  localparam logic [ACC_W-1:0] BIN_MAX = ACC_W'((64'd1 << BIN_W) - 64'd1);

  if (64'(fib_weight(FIB_W + 1)) <= (64'd1 << BIN_W) - 64'd1) begin : g_illegal
    $error("fib_codec: F(FIB_W+1) must exceed 2^BIN_W-1");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FIB_W-1:0] dig_q, dig_d;
  logic [WW-1:0]    wgt;
  logic             load, step, fit, ovf, adj;

  fib_weight_gen #(.WGT_W(WW), .SEED_HI(SEED_HI), .SEED_LO(SEED_LO)) u_wgt (
    .clk(clk), .rst(rst), .load_i(load), .step_i(step), .wgt_o(wgt)
  );

  // acc_q is the encode remainder or the decode running sum, depending on mode
  assign fit = ACC_W'(wgt) <= acc_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    acc_d = acc_q;
    dig_d = dig_q;
    load = 1'b0;
    step = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        cnt_d = CW'(FIB_W - 1);
        mode_d = mode;
        acc_d = mode ? '0 : ACC_W'(bin_in);
        dig_d = mode ? fib_in : '0;
        load = 1'b1;
      end
      RUN: begin
        step = 1'b1;
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? DONE : RUN;
        if (mode_q) acc_d = dig_q[cnt_q] ? acc_q + ACC_W'(wgt) : acc_q;
        else begin
          dig_d[cnt_q] = fit;
          acc_d = fit ? acc_q - ACC_W'(wgt) : acc_q;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mode_q <= 1'b0;
      acc_q <= '0;
      dig_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      acc_q <= acc_d;
      dig_q <= dig_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign busy = !in_ready;
  assign out_valid = state_q == DONE;
  assign ovf = acc_q > BIN_MAX;
  assign adj = |(dig_q & (dig_q >> 1));
  assign err = out_valid && mode_q && (adj || ovf);
  assign fib_out = (out_valid && !mode_q) ? dig_q : '0;
  assign bin_out = (out_valid && mode_q && !err) ? acc_q[BIN_W-1:0] : '0;
endmodule

// File: tb/tb_fib_codec.sv
// tb_fib_codec: directed vectors with a queue scoreboard and a decoupled output monitor.
module tb_fib_codec;
  localparam int BIN_W = 16;
  localparam int FIB_W = 24;

  logic clk = 0, rst = 1, mode = 0, in_valid = 0, out_ready = 1;
  logic [BIN_W-1:0] bin_in = '0, bin_out;
  logic [FIB_W-1:0] fib_in = '0, fib_out;
  logic in_ready, out_valid, err, busy;

  fib_codec #(.BIN_W(BIN_W), .FIB_W(FIB_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .fib_in(fib_in), .out_valid(out_valid), .out_ready(out_ready),
    .fib_out(fib_out), .bin_out(bin_out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FIB_W-1:0] fib;
    logic [BIN_W-1:0] bin;
    logic             err;
    int               acc;
  } exp_t;

  typedef struct packed {
    logic             m;
    logic [BIN_W-1:0] b;
    logic [FIB_W-1:0] f;
    logic [FIB_W-1:0] ef;
    logic [BIN_W-1:0] eb;
    logic             ee;
  } vec_t;

  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  logic pv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: accept edge counts as edge 1, so valid rises on edge FIB_W+1
  always @(negedge clk) begin
    if (out_valid && !pv) begin
      if (q.size() == 0) chk("spurious_out_valid", 1, 0);
      else chk("latency", cyc - q[0].acc + 1, FIB_W + 1);
    end
    if (out_valid && out_ready && q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fib_out", fib_out, e.fib);
      chk("bin_out", bin_out, e.bin);
      chk("err", err, e.err);
    end
    pv = out_valid;
  end

  task automatic issue(input vec_t v);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    mode = v.m;
    bin_in = v.b;
    fib_in = v.f;
    in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    e.fib = v.ef;
    e.bin = v.eb;
    e.err = v.ee;
    e.acc = cyc;
    q.push_back(e);
    mode = ~v.m;
    bin_in = ~v.b;
    fib_in = ~v.f;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  vec_t vecs[12] = '{
    '{1'b0, 16'd0,     24'h000000, 24'h000000, 16'd0,     1'b0},
    '{1'b0, 16'd1,     24'h000000, 24'h000001, 16'd0,     1'b0},
    '{1'b0, 16'd4,     24'h000000, 24'h000005, 16'd0,     1'b0},
    '{1'b0, 16'd100,   24'h000000, 24'h000214, 16'd0,     1'b0},
    '{1'b0, 16'd65535, 24'h000000, 24'h505204, 16'd0,     1'b0},
    '{1'b1, 16'd0,     24'h505204, 24'h000000, 16'd65535, 1'b0},
    '{1'b1, 16'd0,     24'h000214, 24'h000000, 16'd100,   1'b0},
    '{1'b1, 16'd0,     24'h000003, 24'h000000, 16'd0,     1'b1},
    '{1'b1, 16'd0,     24'h000000, 24'h000000, 16'd0,     1'b0},
    '{1'b1, 16'd0,     24'h800000, 24'h000000, 16'd0,     1'b1},
    '{1'b1, 16'd0,     24'h400000, 24'h000000, 16'hB520,  1'b0},
    '{1'b1, 16'd0,     24'h0C0000, 24'h000000, 16'd0,     1'b1}
  };

  vec_t enc100 = '{1'b0, 16'd100, 24'h000000, 24'h000214, 16'd0, 1'b0};

  initial begin
    int n;
    #2 rst = 0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fib_out", fib_out, 0);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    foreach (vecs[i]) issue(vecs[i]);
    drain();

    // Back-pressure: result must hold while out_ready is low
    out_ready = 0;
    issue(enc100);
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_fib_out", fib_out, 24'h000214);
      chk("hold_err", err, 0);
      chk("hold_in_ready", in_ready, 0);
      in_valid = 1;
      mode = 1;
      fib_in = 24'h000003;
      @(posedge clk);
      #1;
      in_valid = 0;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("in_ready_after_take", in_ready, 1);
    issue(vecs[5]);
    drain();

    // Abort mid-run
    @(negedge clk);
    mode = 0;
    bin_in = 16'd100;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("busy_after_accept", busy, 1);
    repeat (9) @(posedge clk);
    #3 rst = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fib_out", fib_out, 0);
    chk("abort_bin_out", bin_out, 0);
    chk("abort_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (40) @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    issue(enc100);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
